aes_128_kat_bist: RTL
=====================

// Module: aes_128_kat_bist
// PURPOSE
// - Built-in known-answer self-test controller for the pipelined aes_128 core.
// - On start, streams NUM_VEC FIPS vectors back-to-back (one per cycle) into the core.
// - Checks each ciphertext LATENCY cycles after issue, then reports pass/fail, error count and first failing index.
// - Sits beside aes_128 and muxes its state/key inputs in self-test mode. This replaces ad-hoc single-vector benches.
// PARAMETERS
// - NUM_VEC  4   vectors run per test, 1..4 (table order 0..NUM_VEC-1)
// - LATENCY  20  cycles from vector on aes_state/aes_key to its result on aes_out, >=1
// - CNT_W    3   width of err_count and fail_idx, >= clog2(NUM_VEC+1)
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      asynchronous active-low reset
// - start      in   1      one-cycle request; honoured in IDLE or DONE only
// - aes_state  out  128    plaintext to aes_128
// - aes_key    out  128    key to aes_128
// - aes_out    in   128    ciphertext from aes_128
// - busy       out  1      high in ISSUE and DRAIN
// - done       out  1      high in DONE; held until next start
// - pass       out  1      done && err_count==0
// - err_count  out  CNT_W  mismatches this run; saturates at all-ones
// - fail_idx   out  CNT_W  index of first mismatch; 0 if none
// BEHAVIOUR
// - Reset (async assert, sync release): FSM=IDLE. aes_state, aes_key, busy, done, pass, err_count, fail_idx all 0.
// - FSM states: IDLE -start-> ISSUE. ISSUE -(issue idx==NUM_VEC-1)-> DRAIN. DRAIN -(last compare)-> DONE. DONE -start-> ISSUE.
// - Cycle counter cyc: cleared on ISSUE entry, +1 per cycle while busy.
// - Start accept: on the start edge, err_count, fail_idx and the first-fail flag clear; done drops.
// - ISSUE: aes_state/aes_key registered from table[cyc], so vector i is driven during cycle i of the run.
// - Outside ISSUE: aes_state/aes_key = 0.
// - Compare: at the edge ending cycle c, for LATENCY <= c <= LATENCY+NUM_VEC-1, compare aes_out against CT[c-LATENCY] (full 128-bit !==).
// - On mismatch: err_count+1 (saturating). The first mismatch loads fail_idx=c-LATENCY.
// - Last compare at c = LATENCY+NUM_VEC-1. DONE is entered on that edge, so done rises the next cycle, with pass valid together with done.
// - start while busy: ignored, no restart, no error.
// - start and last compare on the same edge: the last compare completes and the FSM enters DONE; start is not queued.
// - rst_n low mid-run: immediate return to IDLE with all outputs 0, results discarded.
// - Vector table (key / pt / ct):
// -   0: 2b7e151628aed2a6abf7158809cf4f3c / 3243f6a8885a308d313198a2e0370734 / 3925841d02dc09fbdc118597196a0b32
// -   1: 000102030405060708090a0b0c0d0e0f / 00112233445566778899aabbccddeeff / 69c4e0d86a7b0430d8cdb78070b4c55a
// -   2: 2b7e151628aed2a6abf7158809cf4f3c / 6bc1bee22e409f96e93d7e117393172a / 3ad77bb40d7a3660a89ecaf32466ef97
// -   3: 2b7e151628aed2a6abf7158809cf4f3c / ae2d8a571e03ac9c9eb76fac45af8e51 / f5d3d58503b9699de785895a96fdbaaf
// CONFIGURATION
// - Macro AES_KAT_CAPTURE_EN, when defined:
// -   Adds output fail_data (out, 128): aes_out captured at the first mismatch.
// -   fail_data resets to 0, clears on start accept, and is held until the next start.
// - Without AES_KAT_CAPTURE_EN: port and register are absent. All other behaviour is identical.
// STRUCTURE
// - Package aes_kat_pkg:
// -   KAT_MAX=4
// -   localparam arrays KAT_KEY, KAT_PT, KAT_CT [0:3][127:0]
// -   FSM state enum {IDLE, ISSUE, DRAIN, DONE}
// - Sub-module aes_kat_rom: combinational idx -> {key, pt, ct} lookup, instantiated twice: one read port for issue, one for compare.
// - Top level holds the FSM, cyc counter, compare/accumulate logic and optional capture register.
// TESTING (bench: aes_128 with LATENCY=20, plus a wrapper that XORs aes_out bit0 for a selected index)
// - Reset, no start, 100 cycles: done=0, busy=0, aes_state=aes_key=0.
// - start at cycle 0, clean core:
// -   busy high cycles 1..24; vector 0 driven on cycle 1 with key 2b7e...4f3c, pt 3243...0734.
// -   done=1, pass=1, err_count=0.
// - Corrupt idx 2: pass=0, err_count=1, fail_idx=2. With capture enabled, fail_data=3ad77bb4...ef96.
// - Corrupt idx 1 and 3: err_count=2, fail_idx=1.
// - start pulsed mid-DRAIN: ignored, done timing unchanged. Then start in DONE: re-run clears counts, pass=1.
// - rst_n low at run cycle 10: all outputs 0 on assertion. Then start: full clean run, pass=1.

Source files
------------

// File: rtl/aes_kat_pkg.sv
// Known-answer vectors and FSM encoding for the aes_128 self-test.
// Shared by the lookup ROM and the BIST controller.
package aes_kat_pkg;

   localparam int KAT_MAX = 4;

   localparam logic [0:3][127:0] KAT_KEY = {
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'h000102030405060708090a0b0c0d0e0f,
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'h2b7e151628aed2a6abf7158809cf4f3c
   };

   localparam logic [0:3][127:0] KAT_PT = {
      128'h3243f6a8885a308d313198a2e0370734,
      128'h00112233445566778899aabbccddeeff,
      128'h6bc1bee22e409f96e93d7e117393172a,
      128'hae2d8a571e03ac9c9eb76fac45af8e51
   };

   localparam logic [0:3][127:0] KAT_CT = {
      128'h3925841d02dc09fbdc118597196a0b32,
      128'h69c4e0d86a7b0430d8cdb78070b4c55a,
      128'h3ad77bb40d7a3660a89ecaf32466ef97,
      128'hf5d3d58503b9699de785895a96fdbaaf
   };

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } kat_state_e;

endpackage

// File: rtl/aes_kat_rom.sv
// Combinational lookup of one known-answer vector by index.
// One copy feeds the issue side, another the compare side.
module aes_kat_rom
   import aes_kat_pkg::*;
(
   input  logic [1:0]   idx,
   output logic [127:0] key,
   output logic [127:0] pt,
   output logic [127:0] ct
);

   assign key = KAT_KEY[idx];
   assign pt  = KAT_PT[idx];
   assign ct  = KAT_CT[idx];

endmodule

// File: rtl/aes_128_kat_bist.sv
// Known-answer BIST controller for the pipelined aes_128 core.
// Define AES_KAT_CAPTURE_EN to add fail_data (aes_out at first mismatch).
module aes_128_kat_bist
   import aes_kat_pkg::*;
#(
   parameter int NUM_VEC = 4,
   parameter int LATENCY = 20,
   parameter int CNT_W   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [127:0]     aes_state,
   output logic [127:0]     aes_key,
   input  logic [127:0]     aes_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] fail_idx
`ifdef AES_KAT_CAPTURE_EN
   ,
   output logic [127:0]     fail_data
`endif
);

   localparam int LAST  = LATENCY + NUM_VEC - 1;
   localparam int CYC_W = $clog2(LAST + 2);

   kat_state_e       state;
   logic [CYC_W-1:0] cyc;
   logic [CYC_W-1:0] iss_nxt;
   logic [CYC_W-1:0] cmp_off;
   logic [1:0]       iss_idx;
   logic [1:0]       cmp_idx;
   logic             first_fail;
   logic             accept;
   logic             running;
   logic             in_win;
   logic             last_cmp;
   logic             mism;
   logic [CNT_W-1:0] err_nxt;

   logic [127:0] iss_key, iss_pt, iss_ct;
   logic [127:0] cmp_key, cmp_pt, cmp_ct;
   logic         unused_rom;

   assign accept  = start && (state == IDLE || state == DONE);
   assign running = (state == ISSUE) || (state == DRAIN);

   // In IDLE/DONE the issue port presents vector 0 for the accept edge
   assign iss_nxt = cyc + CYC_W'(1);
   assign iss_idx = (state == ISSUE) ? iss_nxt[1:0] : 2'd0;

   assign cmp_off  = cyc - CYC_W'(LATENCY);
   assign cmp_idx  = cmp_off[1:0];
   assign in_win   = running
                  && cyc >= CYC_W'(LATENCY)
                  && cyc <= CYC_W'(LAST);
   assign last_cmp = in_win && cyc == CYC_W'(LAST);
   assign mism     = in_win && (aes_out !== cmp_ct);

   assign err_nxt = (mism && err_count != '1)
                  ? err_count + CNT_W'(1)
                  : err_count;

   assign unused_rom = ^{iss_ct, cmp_key, cmp_pt};

   aes_kat_rom u_iss_rom (
      .idx (iss_idx),
      .key (iss_key),
      .pt  (iss_pt),
      .ct  (iss_ct)
   );

   aes_kat_rom u_cmp_rom (
      .idx (cmp_idx),
      .key (cmp_key),
      .pt  (cmp_pt),
      .ct  (cmp_ct)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cyc        <= '0;
         aes_state  <= '0;
         aes_key    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_idx   <= '0;
         first_fail <= 1'b0;
`ifdef AES_KAT_CAPTURE_EN
         fail_data  <= '0;
`endif
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (accept) begin
                  state      <= ISSUE;
                  cyc        <= '0;
                  aes_state  <= iss_pt;
                  aes_key    <= iss_key;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  fail_idx   <= '0;
                  first_fail <= 1'b0;
`ifdef AES_KAT_CAPTURE_EN
                  fail_data  <= '0;
`endif
               end
            end
            ISSUE: begin
               cyc <= iss_nxt;
               if (cyc == CYC_W'(NUM_VEC - 1)) begin
                  state     <= DRAIN;
                  aes_state <= '0;
                  aes_key   <= '0;
               end else begin
                  aes_state <= iss_pt;
                  aes_key   <= iss_key;
               end
            end
            DRAIN: begin
               cyc <= iss_nxt;
               if (last_cmp) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_nxt == '0);
               end
            end
            default: ;
         endcase

         // Compares only happen while running, so never collide with accept
         if (in_win) begin
            err_count <= err_nxt;
            if (mism && !first_fail) begin
               first_fail <= 1'b1;
               fail_idx   <= CNT_W'(cmp_off);
`ifdef AES_KAT_CAPTURE_EN
               fail_data  <= aes_out;
`endif
            end
         end
      end
   end

endmodule
